// File: rtl/hdmi_packet_pkg.sv
// Shared types and constants for the HDMI data-island packet serializer.
// A packet is a 24-bit header plus four 56-bit subpackets. The header is
// protected by BCH(32,24) and each subpacket by BCH(64,56). Both codes use
// the same 8-bit parity register and the same update rule.
package hdmi_packet_pkg;

    typedef logic [23:0] packet_header_t;
    typedef logic [55:0] subpacket_t;

    localparam logic [7:0] BCH_POLY          = 8'h83;
    localparam int         PACKET_BEATS      = 32;
    localparam int         HEADER_DATA_BEATS = 24;
    localparam int         SUB_DATA_BEATS    = 28;

    // Beat counter type and the beat numbers where the data phases end.
    localparam int BEAT_W = $clog2(PACKET_BEATS);
    typedef logic [BEAT_W-1:0] beat_t;

    localparam beat_t LAST_BEAT    = beat_t'(PACKET_BEATS - 1);
    localparam beat_t HDR_DATA_END = beat_t'(HEADER_DATA_BEATS);
    localparam beat_t SUB_DATA_END = beat_t'(SUB_DATA_BEATS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/bch_ecc_step.sv
// One bit of the BCH parity update shared by the header and subpacket codes.
// The data bit is folded into the LSB. The register shifts right and
// BCH_POLY is XORed back in when the feedback bit is 1.
module bch_ecc_step
    import hdmi_packet_pkg::*;
(
    input  logic [7:0] i_ecc,
    input  logic       i_bit,
    output logic [7:0] o_ecc
);

    logic w_feedback;

    assign w_feedback = i_ecc[0] ^ i_bit;
    assign o_ecc      = {1'b0, i_ecc[7:1]} ^ (w_feedback ? BCH_POLY : 8'h00);

endmodule

// File: rtl/data_island_packet_serializer.sv
// Data-island packet serializer.
// It accepts one packet through a single-entry holding register with a
// valid/ready handshake. When the island timing asks for a slot, it plays
// the packet out over 32 beats. Each beat carries one header bit and two
// bits of each subpacket. The BCH parity is computed on the fly and sent
// in the tail beats.
// Optional feature macro: HDMI_NULL_PACKET_FILL_EN. When it is defined, a
// slot launched with an empty holding register sends a valid all-zero null
// packet. Without it, such a slot sends its 32 beats with out_valid low.
module data_island_packet_serializer
    import hdmi_packet_pkg::*;
(
    input  logic             clk_pixel,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      header,
    input  logic [3:0][55:0] sub,
    input  logic             island_active,
    output logic             out_valid,
    output logic [8:0]       out_data,
    output logic             out_first,
    output logic             out_last
);

    ser_state_t r_state;
    ser_state_t w_state_next;
    beat_t      r_beat;
    beat_t      w_beat_next;
    logic       w_slot_load;
    logic       w_capture;

    // Holding register (one packet waiting for its slot)
    logic                r_hold_valid;
    packet_header_t      r_hold_hdr;
    subpacket_t [3:0]    r_hold_sub;

    // Packet being sent: shift registers and running parity
    packet_header_t      r_hdr_shift;
    subpacket_t [3:0]    r_sub_shift;
    logic [7:0]          r_hdr_ecc;
    logic [3:0][7:0]     r_sub_ecc;
    logic [7:0]          w_hdr_ecc_next;
    logic [3:0][7:0]     w_sub_ecc_mid;
    logic [3:0][7:0]     w_sub_ecc_next;
    logic                r_slot_valid;
    logic                w_slot_valid_load;

    logic                w_hdr_data_phase;
    logic                w_sub_data_phase;
    logic [8:0]          w_beat_data;

    logic                r_out_valid;
    logic [8:0]          r_out_data;
    logic                r_out_first;
    logic                r_out_last;

    // A full holding register can still take a new packet in a load cycle,
    // because the old entry leaves for the slot at the same edge.
    assign in_ready  = !r_hold_valid || w_slot_load;
    assign w_capture = in_valid && in_ready;

`ifdef HDMI_NULL_PACKET_FILL_EN
    assign w_slot_valid_load = 1'b1;
`else
    assign w_slot_valid_load = r_hold_valid;
`endif

    // State register for the slot sequencer
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_state_next;
            r_beat  <= w_beat_next;
        end
    end

    // Next-state logic: start a slot when requested, and chain slots at beat 31
    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_slot_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_beat_next = '0;
                if (island_active) begin
                    w_slot_load  = 1'b1;
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_beat_next = r_beat + beat_t'(1);
                if (r_beat == LAST_BEAT) begin
                    w_beat_next = '0;
                    if (island_active) begin
                        w_slot_load = 1'b1;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // Holding register: capture has priority, so a same-edge load plus
    // capture leaves the register full with the new packet
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_hdr   <= '0;
            r_hold_sub   <= '0;
        end else if (w_capture) begin
            r_hold_valid <= 1'b1;
            r_hold_hdr   <= header;
            r_hold_sub   <= sub;
        end else if (w_slot_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_hdr_data_phase = (r_beat < HDR_DATA_END);
    assign w_sub_data_phase = (r_beat < SUB_DATA_END);

    bch_ecc_step u_hdr_ecc (
        .i_ecc (r_hdr_ecc),
        .i_bit (r_hdr_shift[0]),
        .o_ecc (w_hdr_ecc_next)
    );

    // Header channel: data bits first, then the frozen parity, LSB first.
    assign w_beat_data[0] = w_hdr_data_phase ? r_hdr_shift[0] : r_hdr_ecc[r_beat[2:0]];

    // Each subpacket takes two parity steps per beat: the even bit first,
    // then the odd bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sub
            bch_ecc_step u_even (
                .i_ecc (r_sub_ecc[gi]),
                .i_bit (r_sub_shift[gi][0]),
                .o_ecc (w_sub_ecc_mid[gi])
            );
            bch_ecc_step u_odd (
                .i_ecc (w_sub_ecc_mid[gi]),
                .i_bit (r_sub_shift[gi][1]),
                .o_ecc (w_sub_ecc_next[gi])
            );
            assign w_beat_data[1 + gi] = w_sub_data_phase ? r_sub_shift[gi][0]
                                                          : r_sub_ecc[gi][{r_beat[1:0], 1'b0}];
            assign w_beat_data[5 + gi] = w_sub_data_phase ? r_sub_shift[gi][1]
                                                          : r_sub_ecc[gi][{r_beat[1:0], 1'b1}];
        end
    endgenerate

    // Slot datapath: on a load, take the held packet (or zeros) and clear
    // the parity. Otherwise shift and accumulate while in the data phases.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_hdr_shift  <= '0;
            r_sub_shift  <= '0;
            r_hdr_ecc    <= '0;
            r_sub_ecc    <= '0;
            r_slot_valid <= 1'b0;
        end else if (w_slot_load) begin
            r_hdr_shift  <= r_hold_valid ? r_hold_hdr : '0;
            r_sub_shift  <= r_hold_valid ? r_hold_sub : '0;
            r_hdr_ecc    <= '0;
            r_sub_ecc    <= '0;
            r_slot_valid <= w_slot_valid_load;
        end else if (r_state == ST_SEND) begin
            if (w_hdr_data_phase) begin
                r_hdr_shift <= r_hdr_shift >> 1;
                r_hdr_ecc   <= w_hdr_ecc_next;
            end
            if (w_sub_data_phase) begin
                for (int i = 0; i < 4; i++) begin
                    r_sub_shift[i] <= r_sub_shift[i] >> 2;
                end
                r_sub_ecc <= w_sub_ecc_next;
            end
        end
    end

    // Registered beat outputs. Framing pulses run even for empty slots.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (r_state == ST_SEND) begin
            r_out_valid <= r_slot_valid;
            r_out_data  <= r_slot_valid ? w_beat_data : '0;
            r_out_first <= (r_beat == '0);
            r_out_last  <= (r_beat == LAST_BEAT);
        end else begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_first = r_out_first;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Bench for data_island_packet_serializer.
// A transaction-level model predicts every output beat and in_ready. Each
// packet is framed as {parity, data}, and the beats are sliced out of that
// frame. A table of packets with hand-derived parity bytes, a few directed
// sequences and a randomized run drive the design.
module tb_data_island_packet_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             island_active;
    logic             out_valid;
    logic [8:0]       out_data;
    logic             out_first;
    logic             out_last;

`ifdef HDMI_NULL_PACKET_FILL_EN
    localparam bit NULL_FILL = 1'b1;
`else
    localparam bit NULL_FILL = 1'b0;
`endif

    data_island_packet_serializer dut (
        .clk_pixel     (clk_pixel),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .header        (header),
        .sub           (sub),
        .island_active (island_active),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_first     (out_first),
        .out_last      (out_last)
    );

    initial forever #5 clk_pixel = ~clk_pixel;

    typedef struct packed {
        logic [23:0]      h;
        logic [3:0][55:0] s;
    } pkt_t;

    typedef struct {
        logic [23:0]      h;
        logic [3:0][55:0] s;
        logic [7:0]       hecc;
        logic [3:0][7:0]  secc;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    int          cyc       = 0;
    int          next_load = 0;
    int          last_load = 0;
    int          acc_cnt   = 0;
    pkt_t        hold_q [$];
    logic [11:0] exp_beat [int];   // {valid, first, last, data} sampled after edge key
    logic [11:0] cap [int];        // same layout, captured from the DUT

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] bch(input logic [55:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            e = {1'b0, e[7:1]} ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [8:0] beat_data(input pkt_t p, input int k);
        logic [31:0] hf;
        logic [63:0] sf;
        logic [8:0]  d;
        hf   = {bch({32'd0, p.h}, 24), p.h};
        d    = '0;
        d[0] = hf[k];
        for (int i = 0; i < 4; i++) begin
            sf       = {bch(p.s[i], 56), p.s[i]};
            d[1 + i] = sf[2 * k];
            d[5 + i] = sf[2 * k + 1];
        end
        return d;
    endfunction

    task automatic sched(input pkt_t p, input bit v, input int e);
        for (int k = 0; k < 32; k++) begin
            exp_beat[e + 1 + k] = {v, (k == 0), (k == 31), (v ? beat_data(p, k) : 9'd0)};
        end
    endtask

    // Transaction model, evaluated at every rising edge
    initial begin
        bit   load;
        bit   ready;
        pkt_t p;
        forever begin
            @(posedge clk_pixel);
            cyc++;
            if (reset) begin
                hold_q.delete();
                next_load = 0;
                for (int k = cyc; k <= cyc + 40; k++) begin
                    if (exp_beat.exists(k)) exp_beat.delete(k);
                end
            end else begin
                load  = island_active && (cyc >= next_load);
                ready = (hold_q.size() == 0) || load;
                if (load) begin
                    if (hold_q.size() > 0) begin
                        p = hold_q.pop_front();
                        sched(p, 1'b1, cyc);
                    end else begin
                        sched('0, NULL_FILL, cyc);
                    end
                    next_load = cyc + 32;
                    last_load = cyc;
                end
                if (in_valid && ready) begin
                    hold_q.push_back({header, sub});
                    acc_cnt++;
                end
            end
        end
    end

    // Output monitor on the falling edge
    initial begin
        logic [11:0] act;
        logic [11:0] expv;
        bit          pred;
        forever begin
            @(negedge clk_pixel);
            if (cyc >= 1) begin
                act      = {out_valid, out_first, out_last, out_data};
                cap[cyc] = act;
                expv     = exp_beat.exists(cyc) ? exp_beat[cyc] : 12'd0;
                chk("beat", act, expv);
                pred = (hold_q.size() == 0) || (island_active && (cyc + 1 >= next_load));
                chk("in_ready", in_ready, pred);
            end
        end
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic scramble();
        logic [63:0] t;
        header = 24'($urandom());
        for (int i = 0; i < 4; i++) begin
            t      = {$urandom(), $urandom()};
            sub[i] = t[55:0];
        end
    endtask

    task automatic offer(input pkt_t p);
        int a0;
        int n;
        a0       = acc_cnt;
        in_valid = 1'b1;
        header   = p.h;
        sub      = p.s;
        n        = 0;
        do begin
            tick();
            n++;
        end while (acc_cnt == a0 && n < 200);
        in_valid = 1'b0;
        scramble();
        chk("offer_accept", (acc_cnt != a0), 1);
    endtask

    task automatic launch(input int n);
        island_active = 1'b1;
        repeat (n) tick();
        island_active = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (cyc < next_load + 2 && n < 300) begin
            tick();
            n++;
        end
        chk("wait_idle_bound", (n < 300), 1);
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t        p;
        logic [63:0] t;
        p.h = 24'($urandom());
        for (int i = 0; i < 4; i++) begin
            t      = {$urandom(), $urandom()};
            p.s[i] = t[55:0];
        end
        return p;
    endfunction

    vec_t tbl [5];

    initial begin
        logic [7:0] g;
        pkt_t       p;
        int         s;
        int         a0;

        // Table: one-hot bits near the end of the data phase give parity
        // values easy to derive by hand (a 1 in the final bit gives 8'h83,
        // and a 1 one bit earlier gives 8'hC2). The parity is linear in the data.
        for (int i = 0; i < 5; i++) begin
            tbl[i].h    = '0;
            tbl[i].s    = '0;
            tbl[i].hecc = '0;
            tbl[i].secc = '0;
        end
        tbl[0].h = 24'h000001;  tbl[0].hecc = 8'h4A;
        tbl[1].h = 24'h800000;  tbl[1].hecc = 8'h83;
        tbl[1].s[0] = 56'h80_0000_0000_0000;  tbl[1].secc[0] = 8'h83;
        tbl[1].s[3] = 56'h40_0000_0000_0000;  tbl[1].secc[3] = 8'hC2;
        tbl[2].h = 24'h400000;  tbl[2].hecc = 8'hC2;
        tbl[2].s[1] = 56'hC0_0000_0000_0000;  tbl[2].secc[1] = 8'h41;
        tbl[3].h = 24'h800001;  tbl[3].hecc = 8'hC9;
        tbl[3].s[2] = 56'h80_0000_0000_0000;  tbl[3].secc[2] = 8'h83;

        reset         = 1'b1;
        in_valid      = 1'b0;
        island_active = 1'b0;
        header        = '0;
        sub           = '0;
        tick();
        tick();
        @(negedge clk_pixel);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_first", out_first, 0);
        chk("rst_out_last",  out_last,  0);
        chk("rst_in_ready",  in_ready,  1);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven packets
        for (int v = 0; v < 5; v++) begin
            p.h = tbl[v].h;
            p.s = tbl[v].s;
            offer(p);
            launch(1);
            wait_idle();
            s = last_load;
            for (int k = 0; k < 8; k++) g[k] = cap[s + 25 + k][0];
            chk($sformatf("tbl%0d_hdr_ecc", v), g, tbl[v].hecc);
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    g[2 * j]     = cap[s + 29 + j][1 + i];
                    g[2 * j + 1] = cap[s + 29 + j][5 + i];
                end
                chk($sformatf("tbl%0d_sub%0d_ecc", v, i), g, tbl[v].secc[i]);
            end
            chk($sformatf("tbl%0d_first", v), cap[s + 1][10], 1);
            chk($sformatf("tbl%0d_last", v),  cap[s + 32][9], 1);
        end

        // Back-to-back: second packet captured in the first slot's load cycle
        offer(rand_pkt());
        @(negedge clk_pixel);
        chk("b2b_ready_full", in_ready, 0);
        tick();
        a0            = acc_cnt;
        p             = rand_pkt();
        island_active = 1'b1;
        in_valid      = 1'b1;
        header        = p.h;
        sub           = p.s;
        tick();
        in_valid = 1'b0;
        scramble();
        chk("b2b_capture_in_load", acc_cnt - a0, 1);
        repeat (63) tick();
        island_active = 1'b0;
        wait_idle();
        chk("b2b_last_then_first", {cap[last_load][9], cap[last_load + 1][10]}, 2'b11);
        chk("b2b_second_valid", cap[last_load + 1][11], 1);

        // Empty holding register
        launch(1);
        wait_idle();
        chk("empty_valid", cap[last_load + 1][11], NULL_FILL);
        chk("empty_first", cap[last_load + 1][10], 1);
        chk("empty_last",  cap[last_load + 32][9], 1);

        // island_active dropped mid-slot
        offer(rand_pkt());
        launch(11);
        wait_idle();
        chk("drop_completes", cap[last_load + 32][9], 1);

        // Reset mid-slot, with a second packet waiting in the holding register
        offer(rand_pkt());
        launch(1);
        offer(rand_pkt());
        while (cyc < last_load + 16) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk_pixel);
        chk("rstmid_out_valid", out_valid, 0);
        chk("rstmid_out_data",  out_data,  0);
        chk("rstmid_in_ready",  in_ready,  1);
        tick();
        launch(1);
        wait_idle();
        chk("rstmid_hold_dropped", cap[last_load + 1][11], NULL_FILL);

        // Randomized traffic, with occasional resets
        for (int c = 0; c < 900; c++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            scramble();
            if ($urandom_range(0, 19) == 0) island_active = ~island_active;
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset         = 1'b0;
        in_valid      = 1'b0;
        island_active = 1'b0;
        wait_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
